imem_arbiter: RTL

Shares the single-port instruction memory between the fetch stage and a boot-loader byte stream. In RUN it passes fetch addresses and instructions straight through, combinationally. On a load request it stalls fetch, drains the pipeline and assembles incoming bytes into little-endian words. It writes the words to memory from address 0, then flushes the core so execution restarts at PC 0. It sits between the fetch stage, the instruction memory and the UART/debug loader.

---
 rtl/imem_arbiter_if.sv | 32 +++
 rtl/imem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between imem_arbiter, the fetch stage, the instruction memory and the loader.
// master: arbiter side; slave: fetch/memory/loader side.
`timescale 1ns/1ps
interface imem_arbiter_if #(parameter int unsigned AW = 14);
  logic [AW-1:0] fetch_addr_i;
  logic [31:0]   fetch_inst_o;
  logic          keep_pc_o;
  logic          flush_o;
  logic [AW-1:0] mem_a_o;
  logic          mem_we_o;
  logic [31:0]   mem_d_o;
  logic [31:0]   mem_spo_i;
  logic          ld_start_i;
  logic [AW:0]   ld_len_i;
  logic [7:0]    ld_byte_i;
  logic          ld_byte_vld_i;
  logic          ld_busy_o;
  logic          ld_done_o;
  logic [7:0]    ld_csum_o;

  modport master (
    input  fetch_addr_i, mem_spo_i, ld_start_i, ld_len_i, ld_byte_i, ld_byte_vld_i,
    output fetch_inst_o, keep_pc_o, flush_o, mem_a_o, mem_we_o, mem_d_o,
           ld_busy_o, ld_done_o, ld_csum_o
  );

  modport slave (
    output fetch_addr_i, mem_spo_i, ld_start_i, ld_len_i, ld_byte_i, ld_byte_vld_i,
    input  fetch_inst_o, keep_pc_o, flush_o, mem_a_o, mem_we_o, mem_d_o,
           ld_busy_o, ld_done_o, ld_csum_o
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the instruction memory between fetch and a boot-loader byte stream.
// Optional feature: define LOADER_CHECKSUM_EN to build the running byte checksum on ld_csum_o.
`timescale 1ns/1ps
module imem_arbiter #(
  parameter int unsigned AW           = 14,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic            clk_i,
  input logic            rst_n_i,
  imem_arbiter_if.master bus
);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned DW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_LOAD,
    S_WRITE,
    S_RESTART
  } state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    byte_idx;
  logic [DW-1:0] drain_cnt;
  logic [31:0]   word_q;
  logic          busy_q;
  logic          flush_q;
  logic          done_q;
  logic          we_q;

  logic          last_word_c;
  logic          byte_acc_c;
  logic          start_acc_c;

  // A byte is taken in LOAD, and in WRITE unless the word being written is the last one.
  always_comb begin
    last_word_c = 1'b0;
    byte_acc_c  = 1'b0;
    start_acc_c = 1'b0;
    last_word_c = ((cnt_q + LW'(1)) == len_q);
    byte_acc_c  = bus.ld_byte_vld_i &&
                  ((state == S_LOAD) || ((state == S_WRITE) && !last_word_c));
    start_acc_c = (state == S_RUN) && bus.ld_start_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_RUN;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      byte_idx  <= '0;
      drain_cnt <= '0;
      word_q    <= '0;
      busy_q    <= 1'b0;
      flush_q   <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;

      if (byte_acc_c) begin
        word_q[{byte_idx, 3'b000} +: 8] <= bus.ld_byte_i;
        byte_idx                        <= byte_idx + 2'd1;
      end

      unique case (state)
        S_RUN: begin
          if (bus.ld_start_i) begin
            len_q     <= bus.ld_len_i;
            cnt_q     <= '0;
            addr_q    <= '0;
            byte_idx  <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b1;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            if (len_q == '0) begin
              flush_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= S_RESTART;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_LOAD: begin
          if (byte_acc_c && (byte_idx == 2'd3)) begin
            we_q  <= 1'b1;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + AW'(1);
          cnt_q  <= cnt_q + LW'(1);
          if (last_word_c) begin
            flush_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= S_RESTART;
          end else begin
            state <= S_LOAD;
          end
        end
        S_RESTART: begin
          busy_q <= 1'b0;
          state  <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Modulo-256 sum of accepted bytes; held after the load completes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csum_q <= '0;
    end else if (start_acc_c) begin
      csum_q <= '0;
    end else if (byte_acc_c) begin
      csum_q <= csum_q + bus.ld_byte_i;
    end
  end

  assign bus.ld_csum_o = csum_q;
`else
  assign bus.ld_csum_o = 8'h00;
`endif

  // Fetch path is a straight wire in RUN; memory belongs to the loader otherwise.
  assign bus.mem_a_o      = (state == S_RUN) ? bus.fetch_addr_i : addr_q;
  assign bus.fetch_inst_o = (state == S_RUN) ? bus.mem_spo_i : NOP;
  assign bus.keep_pc_o    = busy_q;
  assign bus.ld_busy_o    = busy_q;
  assign bus.flush_o      = flush_q;
  assign bus.ld_done_o    = done_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_d_o      = word_q;

endmodule
